// File: rtl/vga_fifo_pkg.sv
// Shared definitions for the VGA/LCD FIFO family: depth computation,
// level/threshold width and output-mode encodings.
package vga_fifo_pkg;

    // Output mode selection for the FWFT parameter
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Level and thresholds carry one bit more than the address so that
    // both 0 and DEPTH can be represented.
    localparam int LVL_EXTRA_BITS = 1;

    function automatic int fifo_depth(input int awidth);
        return 1 << awidth;
    endfunction

endpackage

// File: rtl/vga_fifo_dpram.sv
// Simple dual-port RAM: synchronous write port, synchronous read port with
// read-enable. The read register keeps its value while re is low and is
// clearable, so it can drive the FIFO output directly in registered-read mode.
// Read and write of the same address in one cycle return the old word.
module vga_fifo_dpram
    import vga_fifo_pkg::*;
#(
    parameter int AWIDTH = 7,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              sclr,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);
    localparam int DEPTH = fifo_depth(AWIDTH);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port register, cleared together with the rest of the FIFO
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            rdata <= '0;
        end else if (sclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vga_fifo_ex.sv
// Synchronous FIFO between the Wishbone prefetch engine and the pixel
// generator. Registered-read or first-word-fall-through output, programmable
// almost-full/almost-empty thresholds, fill level and sticky error flags.
//
// In FWFT mode a word travels RAM -> RAM read register (mid stage) -> q
// register. level counts every unread word, including the ones already in
// the mid stage or on q, so the RAM itself holds level - out_valid - mid_valid.
module vga_fifo_ex
    import vga_fifo_pkg::*;
#(
    parameter int AWIDTH = 7,
    parameter int DWIDTH = 32,
    parameter int FWFT   = FIFO_STD
) (
    input  logic                             clk,
    input  logic                             aclr,
    input  logic                             sclr,
    input  logic [DWIDTH-1:0]                d,
    input  logic                             wreq,
    input  logic                             rreq,
    input  logic [AWIDTH+LVL_EXTRA_BITS-1:0] afull_th,
    input  logic [AWIDTH+LVL_EXTRA_BITS-1:0] aempty_th,
    output logic [DWIDTH-1:0]                q,
    output logic                             empty,
    output logic                             full,
    output logic                             afull,
    output logic                             aempty,
    output logic [AWIDTH+LVL_EXTRA_BITS-1:0] level,
    output logic                             ovf,
    output logic                             udf
);
    localparam int                DEPTH    = fifo_depth(AWIDTH);
    localparam int                LW       = AWIDTH + LVL_EXTRA_BITS;
    localparam bit                IS_FWFT  = (FWFT == FIFO_FWFT);
    localparam logic [LW-1:0]     LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]     LVL_ONE  = LW'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [LW-1:0]     level_r;
    logic              ovf_r;
    logic              udf_r;

    logic              out_valid;
    logic              mid_valid;
    logic [DWIDTH-1:0] q_reg;
    logic [DWIDTH-1:0] ram_q;

    logic              full_i;
    logic              empty_i;
    logic              rd_acc;
    logic              wr_acc;
    logic              ram_rd;
    logic              out_load;
    logic [LW-1:0]     ram_cnt;

    assign full_i = (level_r == LVL_FULL);

    // Accept decisions and, in FWFT mode, the prefetch scheduling
    always_comb begin
        empty_i  = (level_r == '0);
        out_load = 1'b0;
        ram_cnt  = '0;
        if (IS_FWFT) begin
            empty_i = !out_valid;
        end
        rd_acc = rreq & !empty_i;
        wr_acc = wreq & (!full_i | rd_acc);
        ram_rd = rd_acc;
        if (IS_FWFT) begin
            ram_cnt  = level_r - {{(LW-1){1'b0}}, out_valid}
                               - {{(LW-1){1'b0}}, mid_valid};
            // q takes the mid word whenever q is free or being popped
            out_load = mid_valid & (!out_valid | rd_acc);
            // refill the mid stage as soon as it is (or becomes) free
            ram_rd   = (ram_cnt != '0) & (!mid_valid | out_load);
        end
    end

    // Pointers, level counter and sticky error flags
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else if (sclr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_acc && !rd_acc) begin
                level_r <= level_r + LVL_ONE;
            end else if (rd_acc && !wr_acc) begin
                level_r <= level_r - LVL_ONE;
            end
            if (wreq && !wr_acc) begin
                ovf_r <= 1'b1;
            end
            if (rreq && empty_i) begin
                udf_r <= 1'b1;
            end
        end
    end

    // FWFT output stage: mid/out valid tracking and the q register
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            out_valid <= 1'b0;
            mid_valid <= 1'b0;
            q_reg     <= '0;
        end else if (sclr) begin
            out_valid <= 1'b0;
            mid_valid <= 1'b0;
            q_reg     <= '0;
        end else if (IS_FWFT) begin
            if (out_load) begin
                q_reg     <= ram_q;
                out_valid <= 1'b1;
            end else if (rd_acc) begin
                out_valid <= 1'b0;
            end
            if (ram_rd) begin
                mid_valid <= 1'b1;
            end else if (out_load) begin
                mid_valid <= 1'b0;
            end
        end
    end

    vga_fifo_dpram #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_ram (
        .clk   (clk),
        .aclr  (aclr),
        .sclr  (sclr),
        .we    (wr_acc & !sclr),
        .waddr (wr_ptr),
        .wdata (d),
        .re    (ram_rd & !sclr),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    assign q      = IS_FWFT ? q_reg : ram_q;
    assign empty  = empty_i;
    assign full   = full_i;
    assign afull  = (level_r >= afull_th);
    assign aempty = (level_r <= aempty_th);
    assign level  = level_r;
    assign ovf    = ovf_r;
    assign udf    = udf_r;

endmodule

// File: tb/tb_vga_fifo_ex.sv
// Bench for vga_fifo_ex: one registered-read and one FWFT instance share the
// same stimulus. A queue-based reference model predicts level/flags/q every
// cycle; a separate monitor pops a per-instance scoreboard on every read the
// DUT accepts and compares the delivered word.
module tb_vga_fifo_ex;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            wedge;
    } ent_t;

    logic          clk = 1'b0;
    logic          aclr, sclr, wreq, rreq;
    logic [DW-1:0] d;
    logic [AW:0]   afull_th, aempty_th;

    logic [DW-1:0] q0, q1;
    logic          empty0, full0, afull0, aempty0, ovf0, udf0;
    logic          empty1, full1, afull1, aempty1, ovf1, udf1;
    logic [AW:0]   level0, level1;

    vga_fifo_ex #(.AWIDTH(AW), .DWIDTH(DW), .FWFT(0)) u_std (
        .clk(clk), .aclr(aclr), .sclr(sclr), .d(d), .wreq(wreq), .rreq(rreq),
        .afull_th(afull_th), .aempty_th(aempty_th), .q(q0), .empty(empty0),
        .full(full0), .afull(afull0), .aempty(aempty0), .level(level0),
        .ovf(ovf0), .udf(udf0)
    );

    vga_fifo_ex #(.AWIDTH(AW), .DWIDTH(DW), .FWFT(1)) u_fwft (
        .clk(clk), .aclr(aclr), .sclr(sclr), .d(d), .wreq(wreq), .rreq(rreq),
        .afull_th(afull_th), .aempty_th(aempty_th), .q(q1), .empty(empty1),
        .full(full1), .afull(afull1), .aempty(aempty1), .level(level1),
        .ovf(ovf1), .udf(udf1)
    );

    always #5 clk = ~clk;

    // reference model state, index 0 = registered read, 1 = FWFT
    ent_t          mq [2][$];
    bit            m_ovf [2];
    bit            m_udf [2];
    int            prev_pop [2];
    logic [DW-1:0] last_q [2];

    logic [DW-1:0] sb [2][$];
    bit            pend;
    logic [DW-1:0] pend_exp;

    int cyc;
    int n_tests;
    int n_fail;

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%s]: got 0x%0h, expected 0x%0h (t=%0t)",
                     nm, (i == 0) ? "std" : "fwft", act, exp, $time);
        end
    endtask

    // Word at the head is readable after edge e. In FWFT mode it shows up
    // two edges after its write, and never before the previous word left q.
    function automatic bit m_vis(input int i, input int e);
        if (mq[i].size() == 0) return 1'b0;
        if (i == 0) return 1'b1;
        return (mq[i][0].wedge + 2 <= e) && (prev_pop[i] <= e);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_ovf[i]    = 1'b0;
            m_udf[i]    = 1'b0;
            prev_pop[i] = -100;
            last_q[i]   = '0;
        end
    endtask

    // Apply the current inputs to the model for edge e
    task automatic m_step(input int e);
        bit vis, rd, wr;
        for (int i = 0; i < 2; i++) begin
            vis = m_vis(i, e - 1);
            if (sclr) begin
                mq[i].delete();
                m_ovf[i]    = 1'b0;
                m_udf[i]    = 1'b0;
                prev_pop[i] = -100;
                last_q[i]   = '0;
            end else begin
                rd = rreq && vis;
                wr = wreq && ((mq[i].size() < DEPTH) || rd);
                if (rreq && !vis) m_udf[i] = 1'b1;
                if (wreq && !wr) m_ovf[i] = 1'b1;
                if (rd) begin
                    last_q[i] = mq[i][0].data;
                    mq[i].delete(0);
                    prev_pop[i] = e;
                end
                if (wr) begin
                    mq[i].push_back('{data: d, wedge: e});
                    sb[i].push_back(d);
                end
            end
        end
    endtask

    task automatic check_all();
        logic [AW:0]   lv;
        logic [DW-1:0] qv;
        logic          em, fu, af, ae, ov, ud;
        int            sz;
        bit            vis;
        for (int i = 0; i < 2; i++) begin
            lv = (i == 0) ? level0  : level1;
            qv = (i == 0) ? q0      : q1;
            em = (i == 0) ? empty0  : empty1;
            fu = (i == 0) ? full0   : full1;
            af = (i == 0) ? afull0  : afull1;
            ae = (i == 0) ? aempty0 : aempty1;
            ov = (i == 0) ? ovf0    : ovf1;
            ud = (i == 0) ? udf0    : udf1;
            sz = mq[i].size();
            vis = m_vis(i, cyc);
            chk("level", i, 32'(lv), 32'(sz));
            chk("full", i, 32'(fu), 32'(sz == DEPTH));
            chk("empty", i, 32'(em), 32'(!vis));
            chk("afull", i, 32'(af), 32'(sz >= int'(afull_th)));
            chk("aempty", i, 32'(ae), 32'(sz <= int'(aempty_th)));
            chk("ovf", i, 32'(ov), 32'(m_ovf[i]));
            chk("udf", i, 32'(ud), 32'(m_udf[i]));
            if (i == 0) chk("q", i, 32'(qv), 32'(last_q[0]));
            else if (vis) chk("q", i, 32'(qv), 32'(mq[1][0].data));
        end
    endtask

    task automatic cycle(input bit w, input logic [DW-1:0] dv, input bit r,
                         input bit s);
        wreq = w;
        d    = dv;
        rreq = r;
        sclr = s;
        m_step(cyc + 1);
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_level"}, 0, 32'(level0), 0);
        chk({nm, "_level"}, 1, 32'(level1), 0);
        chk({nm, "_q"}, 0, 32'(q0), 0);
        chk({nm, "_q"}, 1, 32'(q1), 0);
        chk({nm, "_empty"}, 0, 32'(empty0), 1);
        chk({nm, "_empty"}, 1, 32'(empty1), 1);
        chk({nm, "_full"}, 0, 32'(full0), 0);
        chk({nm, "_aempty"}, 1, 32'(aempty1), 1);
        chk({nm, "_afull"}, 0, 32'(afull0), 32'(afull_th == 0));
        chk({nm, "_ovf"}, 0, 32'(ovf0), 0);
        chk({nm, "_ovf"}, 1, 32'(ovf1), 0);
        chk({nm, "_udf"}, 0, 32'(udf0), 0);
        chk({nm, "_udf"}, 1, 32'(udf1), 0);
    endtask

    // aclr pulse between edges; outputs must be in reset state before the
    // next clock edge arrives
    task automatic aclr_pulse();
        wreq = 1'b0;
        rreq = 1'b0;
        sclr = 1'b0;
        aclr = 1'b0;
        #1;
        chk_reset_state("aclr");
        aclr = 1'b1;
        m_reset();
        sb[0].delete();
        sb[1].delete();
        pend = 1'b0;
    endtask

    // scoreboard monitor: compares the word delivered by every accepted read
    initial begin
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("sb_q", 0, 32'(q0), 32'(pend_exp));
                pend = 1'b0;
            end
            if (sclr) begin
                sb[0].delete();
                sb[1].delete();
            end else begin
                if (rreq && !empty0) begin
                    if (sb[0].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_pop[std]: got an accepted read, expected none (t=%0t)", $time);
                    end else begin
                        pend_exp = sb[0].pop_front();
                        pend     = 1'b1;
                    end
                end
                if (rreq && !empty1) begin
                    if (sb[1].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_pop[fwft]: got an accepted read, expected none (t=%0t)", $time);
                    end else begin
                        chk("sb_q", 1, 32'(q1), 32'(sb[1].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        int wp, rp;
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        aclr      = 1'b0;
        sclr      = 1'b0;
        wreq      = 1'b0;
        rreq      = 1'b0;
        d         = '0;
        afull_th  = 4'd6;
        aempty_th = 4'd2;
        m_reset();
        #12;
        chk_reset_state("rst");
        aclr = 1'b1;
        cycle(0, 8'h00, 0, 0);

        // fill with thresholds 6/2, then one rejected write
        for (int k = 1; k <= 8; k++) begin
            cycle(1, 8'(k), 0, 0);
            chk("fill_level", 0, 32'(level0), 32'(k));
            chk("fill_aempty", 0, 32'(aempty0), 32'(k <= 2));
            chk("fill_afull", 0, 32'(afull0), 32'(k >= 6));
        end
        chk("fill_full", 0, 32'(full0), 1);
        cycle(1, 8'hEE, 0, 0);
        chk("ovf_set", 0, 32'(ovf0), 1);
        chk("ovf_level", 1, 32'(level1), 8);

        // drain, then an underflowing read
        for (int k = 1; k <= 8; k++) begin
            cycle(0, 8'h00, 1, 0);
            chk("drain_q", 0, 32'(q0), 32'(k));
        end
        cycle(0, 8'h00, 1, 0);
        chk("udf_set", 0, 32'(udf0), 1);
        chk("udf_hold_q", 0, 32'(q0), 8'h08);

        // simultaneous read and write while full
        for (int k = 0; k < 8; k++) cycle(1, 8'(8'h21 + k), 0, 0);
        cycle(1, 8'hAA, 1, 0);
        chk("rw_full_level", 0, 32'(level0), 8);
        chk("rw_full_level", 1, 32'(level1), 8);
        for (int k = 0; k < 8; k++) cycle(0, 8'h00, 1, 0);
        chk("rw_full_last", 0, 32'(q0), 8'hAA);

        // FWFT write-to-visible latency and back-to-back pops
        cycle(1, 8'h10, 0, 0);
        chk("fw_lat_n", 1, 32'(empty1), 1);
        chk("fw_lat_level", 1, 32'(level1), 1);
        cycle(0, 8'h00, 0, 0);
        chk("fw_lat_n1", 1, 32'(empty1), 1);
        cycle(0, 8'h00, 0, 0);
        chk("fw_lat_n2", 1, 32'(empty1), 0);
        chk("fw_lat_q", 1, 32'(q1), 8'h10);
        for (int k = 1; k <= 3; k++) cycle(1, 8'(8'h10 + k), 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 8'h00, 1, 0);
            if (k < 3) chk("fw_pop_q", 1, 32'(q1), 32'(8'h11 + k));
            else chk("fw_pop_empty", 1, 32'(empty1), 1);
        end

        // pointer wrap at constant level 3
        for (int k = 0; k < 3; k++) cycle(1, 8'(8'h30 + k), 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 0);
        for (int k = 0; k < 20; k++) begin
            cycle(1, 8'(8'h33 + k), 1, 0);
            chk("wrap_level", 0, 32'(level0), 3);
            chk("wrap_level", 1, 32'(level1), 3);
            chk("wrap_empty", 1, 32'(empty1), 0);
        end

        // sclr at level 5 together with a write
        cycle(1, 8'h50, 0, 0);
        cycle(1, 8'h51, 0, 0);
        cycle(1, 8'h77, 0, 1);
        chk_reset_state("sclr");
        cycle(0, 8'h00, 1, 0);

        // aclr pulse at level 5
        for (int k = 0; k < 5; k++) cycle(1, 8'(8'h60 + k), 0, 0);
        aclr_pulse();
        cycle(0, 8'h00, 0, 0);

        // randomized traffic in write-heavy, read-heavy and balanced phases
        for (int n = 0; n < 600; n++) begin
            case (n / 150)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                2:       begin wp = 95; rp = 95; end
                default: begin wp = 55; rp = 50; end
            endcase
            if (n % 50 == 0) begin
                afull_th  = 4'($urandom_range(0, 9));
                aempty_th = 4'($urandom_range(0, 8));
            end
            if ($urandom_range(0, 149) == 0) aclr_pulse();
            cycle($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
                  $urandom_range(0, 79) == 0);
        end

        cycle(0, 8'h00, 0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fifo_ex.md
# vga_fifo_ex

Second-generation synchronous FIFO for the VGA/LCD controller's pixel and colour-lookup data paths. It buffers words between the Wishbone master prefetch engine and the pixel generator. It extends the basic FIFO with:
- an optional first-word-fall-through (FWFT) output mode,
- programmable almost-full/almost-empty thresholds,
- a fill-level output,
- overflow/underflow protection with sticky error flags.

## Interface

Parameters:
- AWIDTH, 7: address width; DEPTH = 2^AWIDTH usable entries.
- DWIDTH, 32: data width.
- FWFT, 0: 0 = registered-read mode; 1 = first-word-fall-through mode.

Ports:
- clk  in  1  clock, rising edge.
- aclr  in  1  reset, asynchronous, active-low.
- sclr  in  1  synchronous clear, active-high.
- d  in  DWIDTH  write data.
- wreq  in  1  write request.
- rreq  in  1  read/pop request.
- afull_th  in  AWIDTH+1  almost-full threshold.
- aempty_th  in  AWIDTH+1  almost-empty threshold.
- q  out  DWIDTH  read data.
- empty  out  1  no word available to read.
- full  out  1  level == DEPTH.
- afull  out  1  level >= afull_th.
- aempty  out  1  level <= aempty_th.
- level  out  AWIDTH+1  number of unread words held, 0..DEPTH.
- ovf  out  1  sticky overflow.
- udf  out  1  sticky underflow.

## Operation

- **Read accept:** rd_acc = rreq & !empty.
- **Write accept:** wr_acc = wreq & (!full | rd_acc). A simultaneous read and write on a full FIFO are both accepted.
- **Rejected requests:** they never move pointers, never corrupt memory and never change level.
- **Level update:** level +1 on wr_acc & !rd_acc; -1 on rd_acc & !wr_acc; otherwise unchanged.
- **Wrap-around:** pointers are AWIDTH bits and wrap modulo DEPTH. Level never exceeds DEPTH and never goes below 0.
- **Overflow flag:** ovf is set on wreq & !wr_acc.
- **Underflow flag:** udf is set on rreq & empty.
- **Sticky flag clearing:** ovf and udf stay set until sclr or aclr.
- **Threshold flags:** afull and aempty are combinational compares of the registered level. A threshold of 0 for aempty means "empty only"; afull_th > DEPTH means afull never asserts.
- **FWFT=0 mode:**
  - empty = (level == 0).
  - q loads the head word at the edge that accepts the read, so it is valid the cycle after rreq.
  - q holds its value when there is no accepted read.
- **FWFT=1 mode:**
  - empty = !(output word valid).
  - q always shows the head word while empty = 0; rreq acknowledges/pops it.
  - level counts the word currently on q.
  - Internal prefetch stage: sync-read RAM plus output register. It must sustain one pop per cycle while level >= 2.
- **sclr:** synchronously zeroes pointers, level, q, the valid state, ovf and udf. sclr wins over wreq/rreq in the same cycle, and memory contents are don't-care afterwards.
- **aclr:** asynchronously sets the same reset state. Asserting it mid-operation discards all contents.

## Timing

- Reset values: q = 0, empty = 1, full = 0, afull = (afull_th == 0), aempty = 1, level = 0, ovf = 0, udf = 0.
- level, full, empty (FWFT=0), ovf and udf update at the edge of the accepted or rejected request.
- FWFT=0 read latency: 1 cycle, from the rreq edge to q valid.
- FWFT=1 write-to-visible latency:
  - A word written into an empty FIFO at edge N appears on q with empty = 0 after edge N+2.
  - level already reads 1 after edge N.
- FWFT=1 pop: on rd_acc at edge M, the next word is on q after edge M if it was written at or before edge M-2. Otherwise empty asserts until that word arrives.
- Throughput: one write and one read per cycle in both modes. There are no bubbles in steady state.

## Structure

- Shared package vga_fifo_pkg holds:
  - the DEPTH computation function (1 << AWIDTH);
  - the level/threshold width constant;
  - the mode encoding constants FIFO_STD = 0 and FIFO_FWFT = 1.
- One sub-module, vga_fifo_dpram: a simple dual-port RAM with DEPTH × DWIDTH entries, a synchronous write port, a synchronous read port and a read-enable. It is instantiated once.
- Pointer logic, level counter, flag logic and the FWFT prefetch/output stage live in the top module.

## Test plan

All scenarios use AWIDTH=3, DWIDTH=8.

- **Reset and fill/drain (FWFT=0):**
  - Release aclr, then write 0x01..0x08 back-to-back → full = 1 and level = 8 after the 8th edge; a 9th write is rejected and ovf = 1.
  - Read 8 times → q = 0x01..0x08, each appearing one cycle after its rreq; empty = 1 at the end.
  - A further rreq sets udf = 1 and leaves q at 0x08.
- **Simultaneous read and write when full:** with level = 8, assert wreq (d = 0xAA) and rreq in the same cycle → both accepted, level stays 8, ovf stays 0, and 0xAA is the 8th word read out later.
- **Pointer wrap:** run 20 cycles of simultaneous write/read with incrementing data and level held at 3 → output sequence matches input with no gaps, level stays 3.
- **Threshold flags:** set afull_th = 6, aempty_th = 2 and write 7 words one per cycle → aempty deasserts after the 3rd write, afull asserts after the 6th.
- **FWFT=1 latency and pop rate:**
  - Write 0x10 at edge N → q = 0x10 and empty = 0 after edge N+2.
  - After writing 4 words, hold rreq for 4 cycles → q steps 0x10, 0x11, 0x12, 0x13 with no bubble, then empty = 1.
- **Clears mid-operation:**
  - At level = 5, assert sclr together with wreq → level = 0, q = 0, empty = 1, ovf = udf = 0, and the write is discarded.
  - Repeat using an aclr pulse between clock edges → outputs reach the same reset state immediately.
